pipeline_stage_register: RTL

- Generic, parametrised inter-stage pipeline register, replacing the fixed-width per-stage registers (decode/execute, execute/memory, ...).
- Carries a control bundle and a datapath bundle from one stage to the next.
- Adds a valid/ready handshake for stalls, an optional 2-entry skid buffer, and a flush that inserts bubbles.
- Instantiated once per stage boundary, with widths set by the stage.

---
 rtl/pipeline_pkg.sv | 11 +
 rtl/stage_data_slot.sv | 43 ++++
 rtl/pipeline_stage_register.sv | 113 +++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared state type, bubble value and per-boundary bundle widths
package pipeline_pkg;
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} stage_state_t;
    localparam logic CTRL_BUBBLE = 1'b0;
    localparam int ID_EX_CTRL_WIDTH = 9;
    localparam int ID_EX_DATA_WIDTH = 106;
    localparam int EX_MEM_CTRL_WIDTH = 3;
    localparam int EX_MEM_DATA_WIDTH = 133;
    localparam int MEM_WB_CTRL_WIDTH = 2;
    localparam int MEM_WB_DATA_WIDTH = 69;
endpackage

// File: rtl/stage_data_slot.sv
// stage_data_slot: one {ctrl,data} storage entry with load, clear and valid flag
module stage_data_slot #(
    parameter int CTRL_WIDTH = 3,
    parameter int DATA_WIDTH = 133
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  clear,
    input  logic [CTRL_WIDTH-1:0] load_ctrl,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  valid,
    output logic [CTRL_WIDTH-1:0] ctrl,
    output logic [DATA_WIDTH-1:0] data
);
    logic                  valid_q, valid_d;
    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // load wins over clear; clear drops only valid so the payload keeps its last value
    always_comb begin
        valid_d = load | (valid_q & ~clear);
        ctrl_d  = load ? load_ctrl : ctrl_q;
        data_d  = load ? load_data : data_q;
    end

    // entry storage, zeroed by asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign ctrl  = ctrl_q;
    assign data  = data_q;
endmodule

// File: rtl/pipeline_stage_register.sv
// pipeline_stage_register: valid/ready inter-stage register with optional skid entry and flush
module pipeline_stage_register
    import pipeline_pkg::*;
#(
    parameter int CTRL_WIDTH = EX_MEM_CTRL_WIDTH,
    parameter int DATA_WIDTH = EX_MEM_DATA_WIDTH,
    parameter bit SKID_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data
);
    logic                  push, pop;
    logic                  main_load, main_clear, main_valid;
    logic [CTRL_WIDTH-1:0] main_ctrl, load_ctrl;
    logic [DATA_WIDTH-1:0] load_data;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    stage_data_slot #(.CTRL_WIDTH(CTRL_WIDTH), .DATA_WIDTH(DATA_WIDTH)) main (
        .clk(clk), .reset_n(reset_n), .load(main_load), .clear(main_clear),
        .load_ctrl(load_ctrl), .load_data(load_data),
        .valid(main_valid), .ctrl(main_ctrl), .data(out_data)
    );

    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : {CTRL_WIDTH{CTRL_BUBBLE}};

    generate
        if (SKID_EN) begin : g_skid
            stage_state_t          state_q, state_d;
            logic                  in_ready_q, in_ready_d;
            logic                  skid_load, skid_clear, skid_valid;
            logic [CTRL_WIDTH-1:0] skid_ctrl;
            logic [DATA_WIDTH-1:0] skid_data;

            stage_data_slot #(.CTRL_WIDTH(CTRL_WIDTH), .DATA_WIDTH(DATA_WIDTH)) skid (
                .clk(clk), .reset_n(reset_n), .load(skid_load), .clear(skid_clear),
                .load_ctrl(in_ctrl), .load_data(in_data),
                .valid(skid_valid), .ctrl(skid_ctrl), .data(skid_data)
            );

            // the older skid entry always refills main ahead of new input to keep FIFO order
            assign load_ctrl = skid_valid ? skid_ctrl : in_ctrl;
            assign load_data = skid_valid ? skid_data : in_data;

            // occupancy FSM: flush empties both entries, otherwise push/pop move entries
            always_comb begin
                state_d    = state_q;
                main_load  = 1'b0;
                main_clear = 1'b0;
                skid_load  = 1'b0;
                skid_clear = 1'b0;
                if (flush) begin
                    state_d    = EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end else begin
                    case (state_q)
                        EMPTY: if (push) begin
                            main_load = 1'b1;
                            state_d   = BUSY;
                        end
                        BUSY: if (push & ~pop) begin
                            skid_load = 1'b1;
                            state_d   = FULL;
                        end else if (pop & ~push) begin
                            main_clear = 1'b1;
                            state_d    = EMPTY;
                        end else if (push & pop) begin
                            main_load = 1'b1;
                        end
                        FULL: if (pop) begin
                            main_load  = 1'b1;
                            skid_clear = 1'b1;
                            state_d    = BUSY;
                        end
                        default: state_d = EMPTY;
                    endcase
                end
                in_ready_d = state_d != FULL;
            end

            // state and registered ready
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end else begin
                    state_q    <= state_d;
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_single
            assign in_ready   = ~main_valid | out_ready;
            assign main_load  = push & ~flush;
            assign main_clear = flush | pop;
            assign load_ctrl  = in_ctrl;
            assign load_data  = in_data;
        end
    endgenerate
endmodule
